// File: rtl/spi_flash_responder_if.sv
// SPI and memory-port bundle for spi_flash_responder.
//   SPI:    i_SCK, i_CS (active low), i_MOSI in; o_MISO, o_MISO_OE out.
//   Memory: o_mem_addr, o_mem_rd out; i_mem_data in (valid 1 clk after o_mem_rd).
//   Status: o_busy out.
// slave modport is the responder's view; master modport is the bench/controller side.
interface spi_flash_responder_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  i_SCK;
  logic                  i_CS;
  logic                  i_MOSI;
  logic                  o_MISO;
  logic                  o_MISO_OE;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_rd;
  logic [7:0]            i_mem_data;
  logic                  o_busy;

  modport slave (
    input  i_SCK, i_CS, i_MOSI, i_mem_data,
    output o_MISO, o_MISO_OE, o_mem_addr, o_mem_rd, o_busy
  );

  modport master (
    output i_SCK, i_CS, i_MOSI, i_mem_data,
    input  o_MISO, o_MISO_OE, o_mem_addr, o_mem_rd, o_busy
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash responder (READ 0x03, RDSR 0x05, RDID 0x9F) backed by a
// synchronous read-only memory port. All SPI pins are oversampled on clk.
// Ports:
//   clk   - system clock (internal oscillator)
//   reset - asynchronous active-low reset
//   bus   - spi_flash_responder_if.slave: SPI pins, memory read port, busy flag
module spi_flash_responder #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4014,
  parameter logic [7:0]  STATUS_BYTE = 8'h00
) (
  input logic                   clk,
  input logic                   reset,
  spi_flash_responder_if.slave  bus
);

  // Only the low address bits matter, so the input shifter keeps just enough history
  // to form either the command byte or the truncated address.
  localparam int unsigned ShW = (ADDR_WIDTH > 8) ? ADDR_WIDTH - 1 : 7;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StStatus,
    StId,
    StIgnore
  } state_e;

  // Synchronizers and edge-detect history
  logic sck_s1_q, sck_s_q, sck_prev_q;
  logic cs_s1_q, cs_s_q, cs_prev_q;
  logic mosi_s1_q, mosi_s_q;

  state_e                state_q, state_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [ShW-1:0]        shift_q, shift_d;
  logic [ShW:0]          shift_next;
  logic [7:0]            tx_q, tx_d;
  logic                  miso_q, miso_d;
  logic                  oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  rd_dly_q, rd_dly_d;
  logic [1:0]            id_idx_q, id_idx_d;

  logic sck_rise, sck_fall, cs_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_s1_q   <= 1'b0;
      sck_s_q    <= 1'b0;
      sck_prev_q <= 1'b0;
      cs_s1_q    <= 1'b0;
      cs_s_q     <= 1'b0;
      cs_prev_q  <= 1'b0;
      mosi_s1_q  <= 1'b0;
      mosi_s_q   <= 1'b0;
    end else begin
      sck_s1_q   <= bus.i_SCK;
      sck_s_q    <= sck_s1_q;
      sck_prev_q <= sck_s_q;
      cs_s1_q    <= bus.i_CS;
      cs_s_q     <= cs_s1_q;
      cs_prev_q  <= cs_s_q;
      mosi_s1_q  <= bus.i_MOSI;
      mosi_s_q   <= mosi_s1_q;
    end
  end

  assign sck_rise   = sck_s_q & ~sck_prev_q;
  assign sck_fall   = ~sck_s_q & sck_prev_q;
  // A real falling edge is required; synchronizers come out of reset at 0, which must
  // not look like a select.
  assign cs_fall    = cs_prev_q & ~cs_s_q;
  assign shift_next = {shift_q, mosi_s_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      rd_dly_q   <= 1'b0;
      id_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      rd_dly_q   <= rd_dly_d;
      id_idx_q   <= id_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    rd_dly_d   = mem_rd_q;
    id_idx_d   = id_idx_q;

    // CS release beats any SCK edge seen in the same clk.
    if (state_q != StIdle && cs_s_q) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      shift_d   = '0;
      miso_d    = 1'b0;
      oe_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d   = StCmd;
            bit_cnt_d = '0;
          end
        end

        StCmd: begin
          if (sck_rise) begin
            shift_d = shift_next[ShW-1:0];
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              case (shift_next[7:0])
                8'h03: state_d = StAddr;
                8'h05: begin
                  state_d = StStatus;
                  tx_d    = STATUS_BYTE;
                end
                8'h9F: begin
                  state_d  = StId;
                  tx_d     = JEDEC_ID[23:16];
                  id_idx_d = 2'd0;
                end
                default: state_d = StIgnore;
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end

        StAddr: begin
          if (sck_rise) begin
            shift_d = shift_next[ShW-1:0];
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d  = '0;
              mem_addr_d = shift_next[ADDR_WIDTH-1:0];
              mem_rd_d   = 1'b1;
              state_d    = StData;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end

        StData, StStatus, StId: begin
          if (sck_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
            oe_d   = 1'b1;
          end
          if (sck_rise) begin
            if (bit_cnt_q[2:0] == 3'd7) begin
              // Bit 0 of the current byte just completed: set up the next byte.
              bit_cnt_d = '0;
              if (state_q == StData) begin
                mem_addr_d = mem_addr_q + 1'b1;
                mem_rd_d   = 1'b1;
              end else if (state_q == StStatus) begin
                tx_d = STATUS_BYTE;
              end else begin
                case (id_idx_q)
                  2'd0:    tx_d = JEDEC_ID[15:8];
                  2'd1:    tx_d = JEDEC_ID[7:0];
                  default: tx_d = 8'h00;
                endcase
                if (id_idx_q != 2'd3) begin
                  id_idx_d = id_idx_q + 2'd1;
                end
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
          // Memory data lands one clk after the read strobe; SCK phase limits keep this
          // clear of the next fall.
          if (state_q == StData && rd_dly_q) begin
            tx_d = bus.i_mem_data;
          end
        end

        StIgnore: begin
          oe_d = 1'b0;
        end

        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.o_MISO     = miso_q;
  assign bus.o_MISO_OE  = oe_q;
  assign bus.o_mem_addr = mem_addr_q;
  assign bus.o_mem_rd   = mem_rd_q;
  assign bus.o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;
  localparam int AW = 12;
  localparam int H  = 8;  // SCK half-period in clk cycles

  typedef struct {
    logic [31:0] cmd;     // command/address bytes, first byte in [31:24]
    int          n_cmd;
    logic [31:0] exp;     // expected MISO bytes, first in [31:24]
    int          n_rsp;
    logic        exp_oe;
    int          exp_rd;  // expected o_mem_rd pulses in the frame
    logic [11:0] a0;
    logic [11:0] a1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_flash_responder_if #(.ADDR_WIDTH(AW)) bus ();

  spi_flash_responder #(
    .ADDR_WIDTH (AW),
    .JEDEC_ID   (24'hEF4014),
    .STATUS_BYTE(8'h00)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  logic [7:0] mem [4096];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.i_mem_data <= 8'h00;
    else if (bus.o_mem_rd) bus.i_mem_data <= mem[bus.o_mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  logic [11:0] rd_addr [8];
  logic rd_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read strobe monitor: records addresses and flags any strobe wider than one clk.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_mem_rd === 1'b1) begin
        checks++;
        if (rd_prev) begin
          errors++;
          $display("FAIL rd_width: o_mem_rd high for 2 clk at addr %0h", bus.o_mem_addr);
        end
        if (rd_cnt < 8) rd_addr[rd_cnt] = bus.o_mem_addr;
        rd_cnt++;
      end
      rd_prev = (bus.o_mem_rd === 1'b1);
    end
  end

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx,
                      output logic oe_and, output logic oe_or);
    oe_and = 1'b1;
    oe_or  = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      bus.i_MOSI = tx[k];
      repeat (H) @(negedge clk);
      rx[k]  = bus.o_MISO;
      oe_and = oe_and & bus.o_MISO_OE;
      oe_or  = oe_or | bus.o_MISO_OE;
      bus.i_SCK = 1'b1;
      repeat (H) @(negedge clk);
      bus.i_SCK = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] rx;
    logic oa, oo;
    rd_cnt = 0;
    repeat (4) @(negedge clk);
    bus.i_CS = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < v.n_cmd; i++) xfer(v.cmd[31-8*i -: 8], rx, oa, oo);
    for (int i = 0; i < v.n_rsp; i++) begin
      xfer(8'hFF, rx, oa, oo);
      chk($sformatf("%s miso byte%0d", tag, i), {24'h0, rx}, {24'h0, v.exp[31-8*i -: 8]});
      chk($sformatf("%s oe byte%0d", tag, i), {31'h0, v.exp_oe ? oa : oo}, {31'h0, v.exp_oe});
    end
    chk({tag, " busy in frame"}, {31'h0, bus.o_busy}, 32'h1);
    bus.i_CS = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, " busy after cs"}, {31'h0, bus.o_busy}, 32'h0);
    chk({tag, " oe after cs"}, {31'h0, bus.o_MISO_OE}, 32'h0);
    chk({tag, " rd count"}, rd_cnt, v.exp_rd);
    if (v.exp_rd >= 2) begin
      chk({tag, " rd addr0"}, {20'h0, rd_addr[0]}, {20'h0, v.a0});
      chk({tag, " rd addr1"}, {20'h0, rd_addr[1]}, {20'h0, v.a1});
    end
  endtask

  vec_t vecs[5];
  vec_t v_abort;

  initial begin
    logic [7:0] rx;
    logic oa, oo;

    // A READ prefetches the byte after the last one clocked, so 2 bytes -> 3 strobes.
    vecs[0] = '{cmd: 32'h03000010, n_cmd: 4, exp: 32'hA53C0000, n_rsp: 2, exp_oe: 1'b1,
                exp_rd: 3, a0: 12'h010, a1: 12'h011};
    vecs[1] = '{cmd: 32'h03FFFFFF, n_cmd: 4, exp: 32'h11220000, n_rsp: 2, exp_oe: 1'b1,
                exp_rd: 3, a0: 12'hFFF, a1: 12'h000};
    vecs[2] = '{cmd: 32'h9F000000, n_cmd: 1, exp: 32'hEF401400, n_rsp: 4, exp_oe: 1'b1,
                exp_rd: 0, a0: 12'h000, a1: 12'h000};
    vecs[3] = '{cmd: 32'h05000000, n_cmd: 1, exp: 32'h00000000, n_rsp: 2, exp_oe: 1'b1,
                exp_rd: 0, a0: 12'h000, a1: 12'h000};
    vecs[4] = '{cmd: 32'hAB000000, n_cmd: 1, exp: 32'h00000000, n_rsp: 2, exp_oe: 1'b0,
                exp_rd: 0, a0: 12'h000, a1: 12'h000};
    v_abort = '{cmd: 32'h03000005, n_cmd: 4, exp: 32'h5A000000, n_rsp: 1, exp_oe: 1'b1,
                exp_rd: 2, a0: 12'h005, a1: 12'h006};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h010] = 8'hA5;
    mem[12'h011] = 8'h3C;
    mem[12'hFFF] = 8'h11;
    mem[12'h000] = 8'h22;
    mem[12'h005] = 8'h5A;

    bus.i_SCK  = 1'b0;
    bus.i_CS   = 1'b1;
    bus.i_MOSI = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset miso", {31'h0, bus.o_MISO}, 32'h0);
    chk("reset oe", {31'h0, bus.o_MISO_OE}, 32'h0);
    chk("reset addr", {20'h0, bus.o_mem_addr}, 32'h0);
    chk("reset rd", {31'h0, bus.o_mem_rd}, 32'h0);
    chk("reset busy", {31'h0, bus.o_busy}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort after 12 address bits: no strobe, then a clean READ works.
    rd_cnt = 0;
    repeat (4) @(negedge clk);
    bus.i_CS = 1'b0;
    repeat (4) @(negedge clk);
    xfer(8'h03, rx, oa, oo);
    for (int k = 0; k < 12; k++) begin
      bus.i_MOSI = 1'b1;
      repeat (H) @(negedge clk);
      bus.i_SCK = 1'b1;
      repeat (H) @(negedge clk);
      bus.i_SCK = 1'b0;
    end
    bus.i_CS = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort busy", {31'h0, bus.o_busy}, 32'h0);
    chk("abort rd count", rd_cnt, 0);
    run_vec(v_abort, "after_abort");

    // Reset in the middle of a DATA byte.
    repeat (4) @(negedge clk);
    bus.i_CS = 1'b0;
    repeat (4) @(negedge clk);
    xfer(8'h03, rx, oa, oo);
    xfer(8'h00, rx, oa, oo);
    xfer(8'h00, rx, oa, oo);
    xfer(8'h10, rx, oa, oo);
    for (int k = 0; k < 3; k++) begin
      repeat (H) @(negedge clk);
      bus.i_SCK = 1'b1;
      repeat (H) @(negedge clk);
      bus.i_SCK = 1'b0;
    end
    repeat (H) @(negedge clk);
    chk("mid-data oe", {31'h0, bus.o_MISO_OE}, 32'h1);
    chk("mid-data addr", {20'h0, bus.o_mem_addr}, 32'h010);
    rst_n = 1'b0;
    #1;
    chk("rst miso", {31'h0, bus.o_MISO}, 32'h0);
    chk("rst oe", {31'h0, bus.o_MISO_OE}, 32'h0);
    chk("rst addr", {20'h0, bus.o_mem_addr}, 32'h0);
    chk("rst rd", {31'h0, bus.o_mem_rd}, 32'h0);
    chk("rst busy", {31'h0, bus.o_busy}, 32'h0);
    bus.i_CS = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[2], "rdid_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
